// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the I-cache
// refill requester (port 0) and the D-cache refill/write-back requester
// (port 1). Each grant moves one whole cache line as LINE_WORDS beats.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          ic_req_i,
    input  logic [ADDR_W-1:0]             ic_addr_i,
    output logic                          ic_rvalid_o,
    output logic                          ic_done_o,
    input  logic                          dc_req_i,
    input  logic                          dc_we_i,
    input  logic [ADDR_W-1:0]             dc_addr_i,
    input  logic [DATA_W-1:0]             dc_wdata_i,
    output logic                          dc_rvalid_o,
    output logic                          dc_done_o,
    output logic [DATA_W-1:0]             rdata_o,
    output logic [$clog2(LINE_WORDS)-1:0] beat_o,
    output logic                          owner_o,
    output logic                          busy_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic [DATA_W-1:0]             mem_wdata_o,
    input  logic                          mem_ack_i,
    input  logic [DATA_W-1:0]             mem_rdata_i
);

    localparam int BEAT_W  = $clog2(LINE_WORDS);
    localparam int BYTE_SH = $clog2(DATA_W / 8);
    // Byte-offset bits inside a line; cleared to form the aligned base.
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS * (DATA_W / 8) - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [BEAT_W-1:0]   beat_r, beat_s;
    logic                owner_r, owner_s;
    logic                last_owner_r, last_owner_s;
    logic                we_r, we_s;
    logic [ADDR_W-1:0]   base_r, base_s;
    logic                grant_port_s;
    logic [ADDR_W-1:0]   grant_addr_s;

    // Pick the port to grant: on a tie the port that did not go last wins.
    always_comb begin
        grant_port_s = 1'b0;
        if (ic_req_i && dc_req_i) begin
            grant_port_s = ~last_owner_r;
        end else if (dc_req_i) begin
            grant_port_s = 1'b1;
        end else begin
            grant_port_s = 1'b0;
        end
        grant_addr_s = (grant_port_s ? dc_addr_i : ic_addr_i) & ~OFF_MASK;
    end

    // State register and latched burst context; last_owner resets to the
    // D-cache so the I-cache wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            beat_r       <= '0;
            owner_r      <= 1'b0;
            last_owner_r <= 1'b1;
            we_r         <= 1'b0;
            base_r       <= '0;
        end else begin
            state_r      <= state_s;
            beat_r       <= beat_s;
            owner_r      <= owner_s;
            last_owner_r <= last_owner_s;
            we_r         <= we_s;
            base_r       <= base_s;
        end
    end

    // Next-state logic and all port outputs for the current state.
    always_comb begin
        state_s      = state_r;
        beat_s       = beat_r;
        owner_s      = owner_r;
        last_owner_s = last_owner_r;
        we_s         = we_r;
        base_s       = base_r;
        ic_rvalid_o  = 1'b0;
        ic_done_o    = 1'b0;
        dc_rvalid_o  = 1'b0;
        dc_done_o    = 1'b0;
        rdata_o      = '0;
        busy_o       = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        beat_o       = beat_r;
        owner_o      = owner_r;

        case (state_r)
            ST_IDLE: begin
                if (ic_req_i || dc_req_i) begin
                    owner_s = grant_port_s;
                    base_s  = grant_addr_s;
                    we_s    = grant_port_s & dc_we_i;
                    beat_s  = '0;
                    state_s = ST_XFER;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                mem_req_o   = 1'b1;
                busy_o      = 1'b1;
                mem_we_o    = we_r;
                mem_addr_o  = base_r + (ADDR_W'(beat_r) << BYTE_SH);
                // The D-cache presents the word selected by beat_o.
                mem_wdata_o = dc_wdata_i;
                if (mem_ack_i) begin
                    if (!we_r) begin
                        rdata_o     = mem_rdata_i;
                        ic_rvalid_o = ~owner_r;
                        dc_rvalid_o = owner_r;
                    end else begin
                        rdata_o     = '0;
                    end
                    // Power-of-two line length: the increment wraps to 0.
                    beat_s = beat_r + BEAT_W'(1);
                    if (beat_r == LAST_BEAT) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_XFER;
                    end
                end else begin
                    state_s = ST_XFER;
                end
            end
            ST_DONE: begin
                busy_o       = 1'b1;
                ic_done_o    = ~owner_r;
                dc_done_o    = owner_r;
                last_owner_s = owner_r;
                state_s      = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                beat_s  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. Inputs change 1 ns
// after the rising edge; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ic_req_i;
    logic [31:0] ic_addr_i;
    logic        ic_rvalid_o, ic_done_o;
    logic        dc_req_i, dc_we_i;
    logic [31:0] dc_addr_i, dc_wdata_i;
    logic        dc_rvalid_o, dc_done_o;
    logic [31:0] rdata_o;
    logic [1:0]  beat_o;
    logic        owner_o, busy_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i),
        .ic_rvalid_o(ic_rvalid_o), .ic_done_o(ic_done_o),
        .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i),
        .dc_wdata_i(dc_wdata_i), .dc_rvalid_o(dc_rvalid_o), .dc_done_o(dc_done_o),
        .rdata_o(rdata_o), .beat_o(beat_o), .owner_o(owner_o), .busy_o(busy_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; ic_req_i = 1'b0; dc_req_i = 1'b0; dc_we_i = 1'b0;
        ic_addr_i = 32'h0; dc_addr_i = 32'h0; mem_ack_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst_i = 1'b1; mem_ack_i = 1'b1;
        dc_wdata_i = 32'hFFFF_FFFF; mem_rdata_i = 32'hFFFF_FFFF;
        step();
        @(negedge clk_i);
        checks++; if ({mem_req_o, mem_we_o, busy_o} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b want 000", {mem_req_o, mem_we_o, busy_o}); end
        checks++; if ({ic_done_o, dc_done_o, ic_rvalid_o, dc_rvalid_o} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b want 0000", {ic_done_o, dc_done_o, ic_rvalid_o, dc_rvalid_o}); end
        checks++; if ({owner_o, beat_o} !== 3'b000) begin errors++; $display("FAIL reset_owner_beat: got %b want 000", {owner_o, beat_o}); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_addr_o); end
        checks++; if (mem_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", mem_wdata_o); end
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata_o); end
        rst_i = 1'b0; mem_ack_i = 1'b0; dc_wdata_i = 32'h0;
    endtask

    task automatic test_icache_only();
        do_reset();
        ic_req_i = 1'b1; ic_addr_i = 32'h0000_104C; mem_ack_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            mem_rdata_i = 32'hC0DE_0000 + 32'(k);
            @(negedge clk_i);
            checks++; if (mem_addr_o !== 32'h1040 + 32'(4 * k)) begin errors++; $display("FAIL ic_addr beat %0d: got %h want %h", k, mem_addr_o, 32'h1040 + 32'(4 * k)); end
            checks++; if ({mem_req_o, mem_we_o, busy_o, owner_o} !== 4'b1010) begin errors++; $display("FAIL ic_ctrl beat %0d: got %b want 1010", k, {mem_req_o, mem_we_o, busy_o, owner_o}); end
            checks++; if ({ic_rvalid_o, dc_rvalid_o, ic_done_o} !== 3'b100) begin errors++; $display("FAIL ic_rvalid beat %0d: got %b want 100", k, {ic_rvalid_o, dc_rvalid_o, ic_done_o}); end
            checks++; if (rdata_o !== 32'hC0DE_0000 + 32'(k)) begin errors++; $display("FAIL ic_rdata beat %0d: got %h want %h", k, rdata_o, 32'hC0DE_0000 + 32'(k)); end
            checks++; if (beat_o !== 2'(k)) begin errors++; $display("FAIL ic_beat: got %0d want %0d", beat_o, k); end
        end
        step();
        ic_req_i = 1'b0;
        @(negedge clk_i);
        checks++; if ({ic_done_o, dc_done_o, mem_req_o, busy_o, ic_rvalid_o} !== 5'b10010) begin errors++; $display("FAIL ic_done: got %b want 10010", {ic_done_o, dc_done_o, mem_req_o, busy_o, ic_rvalid_o}); end
        checks++; if (beat_o !== 2'd0) begin errors++; $display("FAIL ic_beat_wrap: got %0d want 0", beat_o); end
        step();
        @(negedge clk_i);
        checks++; if ({ic_done_o, busy_o, mem_req_o} !== 3'b000) begin errors++; $display("FAIL ic_idle: got %b want 000", {ic_done_o, busy_o, mem_req_o}); end
    endtask

    task automatic test_dcache_writeback();
        int eb;
        int acks;
        do_reset();
        dc_req_i = 1'b1; dc_we_i = 1'b1; dc_addr_i = 32'h0000_2000;
        eb = 0; acks = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            mem_ack_i = (c % 2 == 1);
            dc_wdata_i = 32'hA0 + 32'(eb);
            mem_rdata_i = 32'hDEAD_BEEF;
            @(negedge clk_i);
            checks++; if (mem_addr_o !== 32'h2000 + 32'(4 * eb)) begin errors++; $display("FAIL dc_addr cycle %0d: got %h want %h", c, mem_addr_o, 32'h2000 + 32'(4 * eb)); end
            checks++; if (mem_wdata_o !== 32'hA0 + 32'(eb)) begin errors++; $display("FAIL dc_wdata cycle %0d: got %h want %h", c, mem_wdata_o, 32'hA0 + 32'(eb)); end
            checks++; if ({mem_req_o, mem_we_o, owner_o, beat_o} !== {3'b111, 2'(eb)}) begin errors++; $display("FAIL dc_ctrl cycle %0d: got %b want %b", c, {mem_req_o, mem_we_o, owner_o, beat_o}, {3'b111, 2'(eb)}); end
            checks++; if ({dc_rvalid_o, ic_rvalid_o, dc_done_o, rdata_o} !== 35'h0) begin errors++; $display("FAIL dc_norvalid cycle %0d: got %b/%h want 0", c, {dc_rvalid_o, ic_rvalid_o, dc_done_o}, rdata_o); end
            if (mem_ack_i) begin
                eb++;
                acks++;
            end
        end
        step();
        dc_req_i = 1'b0; mem_ack_i = 1'b0;
        @(negedge clk_i);
        checks++; if ({dc_done_o, ic_done_o, mem_req_o, acks == 4} !== 4'b1001) begin errors++; $display("FAIL dc_done: got %b want 1001", {dc_done_o, ic_done_o, mem_req_o, acks == 4}); end
        step();
        @(negedge clk_i);
        checks++; if ({dc_done_o, busy_o} !== 2'b00) begin errors++; $display("FAIL dc_done_once: got %b want 00", {dc_done_o, busy_o}); end
        dc_we_i = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic exp_owner;
        rst_i = 1'b1; ic_req_i = 1'b1; dc_req_i = 1'b1; dc_we_i = 1'b0;
        ic_addr_i = 32'h0000_0100; dc_addr_i = 32'h0000_0200; mem_ack_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            exp_owner = (b % 2 == 1);
            for (int c = 0; c < 6; c++) begin
                step();
                if (b == 3 && c == 4) begin
                    ic_req_i = 1'b0;
                    dc_req_i = 1'b0;
                end
                @(negedge clk_i);
                checks++; if (ic_done_o & dc_done_o) begin errors++; $display("FAIL rr_done_overlap: got both done high want at most one"); end
                if (c < 4) begin
                    checks++; if ({owner_o, mem_req_o, ic_rvalid_o, dc_rvalid_o} !== {exp_owner, 1'b1, ~exp_owner, exp_owner}) begin errors++; $display("FAIL rr_grant burst %0d: got %b want %b", b, {owner_o, mem_req_o, ic_rvalid_o, dc_rvalid_o}, {exp_owner, 1'b1, ~exp_owner, exp_owner}); end
                    checks++; if (mem_addr_o !== (exp_owner ? 32'h200 : 32'h100) + 32'(4 * c)) begin errors++; $display("FAIL rr_addr burst %0d: got %h want %h", b, mem_addr_o, (exp_owner ? 32'h200 : 32'h100) + 32'(4 * c)); end
                end else if (c == 4) begin
                    checks++; if ({ic_done_o, dc_done_o} !== {~exp_owner, exp_owner}) begin errors++; $display("FAIL rr_done burst %0d: got %b want %b", b, {ic_done_o, dc_done_o}, {~exp_owner, exp_owner}); end
                end else begin
                    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rr_gap burst %0d: got busy %b want 0", b, busy_o); end
                end
            end
        end
        mem_ack_i = 1'b0;
    endtask

    task automatic test_drop_midburst();
        do_reset();
        dc_req_i = 1'b1; dc_we_i = 1'b0; dc_addr_i = 32'h0000_301C; mem_ack_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 2) begin
                dc_req_i = 1'b0; dc_addr_i = 32'h0000_5000; dc_we_i = 1'b1;
            end
            @(negedge clk_i);
            checks++; if (mem_addr_o !== 32'h3010 + 32'(4 * k)) begin errors++; $display("FAIL drop_addr beat %0d: got %h want %h", k, mem_addr_o, 32'h3010 + 32'(4 * k)); end
            checks++; if ({mem_req_o, mem_we_o, dc_rvalid_o} !== 3'b101) begin errors++; $display("FAIL drop_ctrl beat %0d: got %b want 101", k, {mem_req_o, mem_we_o, dc_rvalid_o}); end
        end
        step();
        @(negedge clk_i);
        checks++; if ({dc_done_o, ic_done_o} !== 2'b10) begin errors++; $display("FAIL drop_done: got %b want 10", {dc_done_o, ic_done_o}); end
        step();
        step();
        @(negedge clk_i);
        checks++; if ({mem_req_o, busy_o} !== 2'b00) begin errors++; $display("FAIL drop_no_regrant: got %b want 00", {mem_req_o, busy_o}); end
        dc_we_i = 1'b0;
    endtask

    task automatic test_reset_midburst();
        do_reset();
        dc_req_i = 1'b1; dc_addr_i = 32'h0000_6000; ic_addr_i = 32'h0000_7004; mem_ack_i = 1'b1;
        step();
        step();
        step();
        rst_i = 1'b1; ic_req_i = 1'b1;
        @(negedge clk_i);
        checks++; if ({mem_req_o, owner_o, beat_o} !== 4'b1110) begin errors++; $display("FAIL rstmid_pre: got %b want 1110", {mem_req_o, owner_o, beat_o}); end
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++; if ({mem_req_o, busy_o, dc_done_o, ic_done_o, beat_o} !== 6'b0) begin errors++; $display("FAIL rstmid_abort: got %b want 000000", {mem_req_o, busy_o, dc_done_o, ic_done_o, beat_o}); end
        step();
        @(negedge clk_i);
        checks++; if ({mem_req_o, owner_o, dc_done_o} !== 3'b100) begin errors++; $display("FAIL rstmid_tie: got %b want 100", {mem_req_o, owner_o, dc_done_o}); end
        checks++; if (mem_addr_o !== 32'h7000) begin errors++; $display("FAIL rstmid_addr: got %h want 00007000", mem_addr_o); end
        do_reset();
    endtask

    task automatic test_stall();
        do_reset();
        ic_req_i = 1'b1; ic_addr_i = 32'h0000_4008; mem_ack_i = 1'b0;
        step();
        for (int c = 0; c < 10; c++) begin
            step();
            @(negedge clk_i);
            checks++; if ({mem_req_o, beat_o, ic_rvalid_o, mem_addr_o} !== {1'b1, 2'd0, 1'b0, 32'h4000}) begin errors++; $display("FAIL stall cycle %0d: got %b/%h want 1000/00004000", c, {mem_req_o, beat_o, ic_rvalid_o}, mem_addr_o); end
        end
        step();
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        checks++; if ({ic_rvalid_o, mem_addr_o} !== {1'b1, 32'h4000}) begin errors++; $display("FAIL stall_release: got %b/%h want 1/00004000", ic_rvalid_o, mem_addr_o); end
        step();
        @(negedge clk_i);
        checks++; if ({beat_o, mem_addr_o} !== {2'd1, 32'h4004}) begin errors++; $display("FAIL stall_next: got %0d/%h want 1/00004004", beat_o, mem_addr_o); end
        do_reset();
    endtask

    initial begin
        rst_i = 1'b1; ic_req_i = 1'b0; ic_addr_i = 32'h0; dc_req_i = 1'b0; dc_we_i = 1'b0;
        dc_addr_i = 32'h0; dc_wdata_i = 32'h0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        test_reset();
        test_icache_only();
        test_dcache_writeback();
        test_simultaneous();
        test_drop_midburst();
        test_reset_midburst();
        test_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
